fp_add_sched: RTL and testbench
===============================

FP_ADD_SCHED -- requirements
Module: fp_add_sched

Interface
REQ-001 The module SHALL have parameter COUNT_W, default 16, giving the width of the completed-operation counter.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-004 The module SHALL have port req_valid, input, 2, where bit i means requester i presents an operand pair.
REQ-005 The module SHALL have ports req0_a and req0_b, input, 32 each, holding requester 0's IEEE-754 single-precision operands.
REQ-006 The module SHALL have ports req1_a and req1_b, input, 32 each, holding requester 1's IEEE-754 single-precision operands.
REQ-007 The module SHALL have port req_ready, output, 2, where bit i means requester i's operands are accepted this cycle.
REQ-008 The module SHALL have port rsp_valid, output, 1, meaning a result is presented.
REQ-009 The module SHALL have port rsp_id, output, 1, giving the index of the requester that owns the result.
REQ-010 The module SHALL have port rsp_sum, output, 32, giving the single-precision sum A+B.
REQ-011 The module SHALL have port rsp_ready, input, 1, meaning the consumer accepts the result.
REQ-012 The module SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 The module SHALL have port op_count, output, COUNT_W, counting completed result handshakes.

Function
REQ-014 The module SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-015 In IDLE, when any req_valid bit is high, the module SHALL grant exactly one requester, assert only that requester's req_ready bit in the same cycle, latch its A/B into operand registers and its index into the owner register, and move to EXEC.
REQ-016 req_ready SHALL be combinational: (state==IDLE) AND grant[i]; it is 0 in EXEC and DONE.
REQ-017 Arbitration SHALL be round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted last is granted; the last_grant register updates only on a grant.
REQ-018 In EXEC, the registered operands SHALL drive the shared fp_adder; its Sum is captured into the result register, and the state moves to DONE.
REQ-019 In DONE, rsp_valid SHALL be 1, with rsp_sum and rsp_id held stable until rsp_ready is 1.
REQ-020 On rsp_valid AND rsp_ready, the module SHALL return to IDLE and increment op_count, saturating at all-ones.
REQ-021 Latency: for a request accepted at the edge ending cycle N, rsp_valid SHALL first be 1 in cycle N+2; minimum issue interval is 3 cycles.
REQ-022 If rsp_ready is already 1 on the first DONE cycle, the handshake SHALL complete in that cycle.
REQ-023 Outside DONE, rsp_valid SHALL be 0 and rsp_sum/rsp_id SHALL hold their last registered values.
REQ-024 Requests arriving while not in IDLE SHALL be ignored; requesters hold req_valid until they see req_ready.

Reset
REQ-025 When rst is asserted, the module SHALL asynchronously set the state to IDLE, the operand, result, owner and op_count registers to 0, and last_grant to 1, so that requester 0 wins the first tie.
REQ-026 A reset asserted in EXEC or DONE SHALL discard the in-flight operation without producing a response or incrementing the count.
REQ-027 During reset, req_ready, rsp_valid and busy SHALL be 0.

Structure
REQ-028 Shared package fp_add_pkg SHALL define the FSM state enum, FP_W=32, N_REQ=2 and ID_W=1.
REQ-029 The module SHALL contain exactly one instance of the existing combinational fp_adder (ports A, B, Sum) as its sole sub-module.

Verification
REQ-030 The bench SHALL cover single requests: req0 with 0x40400000+0x40000000 -> rsp_sum 0x40A00000, rsp_id 0, and rsp_valid 2 cycles after acceptance.
REQ-031 The bench SHALL cover signed and cancelling inputs: req1 with 0xC0400000+0x40000000 -> 0xBF800000, rsp_id 1; and 0x3F800000+0xBF800000 -> 0x00000000.
REQ-032 The bench SHALL cover a tie after reset: both valid, req0 with 0x3F800000+0x3F800000 and req1 with 0x40400000+0x40000000 -> first 0x40000000/id0, then 0x40A00000/id1, and op_count=2.
REQ-033 The bench SHALL cover back-pressure: rsp_ready held 0 for 5 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable, req_ready=00, busy=1; the response completes on the cycle rsp_ready rises.
REQ-034 The bench SHALL cover reset mid-operation: rst pulsed during EXEC -> no rsp_valid, op_count=0, and a subsequent tie grants req0.
REQ-035 The bench SHALL cover saturation: with COUNT_W=2, 5 completed operations -> op_count=3.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the two-requester floating-point add scheduler.
// Also holds the leading-zero counter used by the adder's normaliser.
package fp_add_pkg;
  localparam int FP_W  = 32;
  localparam int N_REQ = 2;
  localparam int ID_W  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of zeros above the highest set bit of a 27-bit value (27 when all clear).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with subnormal support; overflow goes to infinity, invalid ops to a quiet NaN.
module fp_adder
  import fp_add_pkg::*;
(
  input  logic [FP_W-1:0] A,
  input  logic [FP_W-1:0] B,
  output logic [FP_W-1:0] Sum
);
  logic [FP_W-1:0] w_x, w_y;
  logic [7:0]      w_ex, w_ey, w_diff, w_exm1;
  logic [23:0]     w_mx, w_my;
  logic [26:0]     w_ybase, w_mask, w_yal, w_n;
  logic [27:0]     w_s;
  logic [4:0]      w_lz, w_sh;
  logic [9:0]      w_en, w_ef;
  logic [24:0]     w_mr;
  logic            w_sub, w_rnd, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  // w_x is the operand of larger magnitude, so the aligned difference never goes negative.
  assign w_x    = (A[30:0] >= B[30:0]) ? A : B;
  assign w_y    = (A[30:0] >= B[30:0]) ? B : A;
  assign w_ex   = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
  assign w_ey   = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
  assign w_mx   = {|w_x[30:23], w_x[22:0]};
  assign w_my   = {|w_y[30:23], w_y[22:0]};
  assign w_diff = w_ex - w_ey;
  assign w_sub  = w_x[31] ^ w_y[31];

  // Align with guard/round/sticky; everything shifted out collapses into the sticky bit.
  assign w_ybase = {w_my, 3'b000};
  assign w_mask  = (27'd1 << w_diff) - 27'd1;
  assign w_yal   = (w_diff >= 8'd27) ? {26'd0, |w_my}
                 : ((w_ybase >> w_diff) | {26'd0, |(w_ybase & w_mask)});
  assign w_s     = w_sub ? ({1'b0, w_mx, 3'b000} - {1'b0, w_yal})
                         : ({1'b0, w_mx, 3'b000} + {1'b0, w_yal});

  // Left shift is capped so the exponent stops at 1, producing subnormals.
  assign w_lz   = lzc27(w_s[26:0]);
  assign w_exm1 = w_ex - 8'd1;
  assign w_sh   = (w_exm1 < {3'd0, w_lz}) ? w_exm1[4:0] : w_lz;
  assign w_n    = w_s[27] ? {w_s[27:2], w_s[1] | w_s[0]} : (w_s[26:0] << w_sh);
  assign w_en   = w_s[27] ? ({2'd0, w_ex} + 10'd1) : ({2'd0, w_ex} - {5'd0, w_sh});

  assign w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
  assign w_mr  = {1'b0, w_n[26:3]} + {24'd0, w_rnd};
  assign w_ef  = w_mr[24] ? (w_en + 10'd1) : (w_mr[23] ? w_en : 10'd0);

  assign w_a_nan = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
  assign w_b_nan = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
  assign w_a_inf = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
  assign w_b_inf = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);

  always_comb begin
    Sum = {w_x[31], w_ef[7:0], (w_mr[24] ? w_mr[23:1] : w_mr[22:0])};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (A[31] != B[31]))) begin
      Sum = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      Sum = A;
    end else if (w_b_inf) begin
      Sum = B;
    end else if (w_s == 28'd0) begin
      Sum = {(w_sub ? 1'b0 : w_x[31]), 31'd0};
    end else if (w_ef >= 10'd255) begin
      Sum = {w_x[31], 8'hFF, 23'd0};
    end
  end
endmodule

// File: rtl/fp_add_sched.sv
// Two-requester round-robin front end sharing one combinational fp_adder;
// one operation in flight at a time: IDLE grants, EXEC computes, DONE presents.
module fp_add_sched
  import fp_add_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [FP_W-1:0]    req0_a,
  input  logic [FP_W-1:0]    req0_b,
  input  logic [FP_W-1:0]    req1_a,
  input  logic [FP_W-1:0]    req1_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [FP_W-1:0]    rsp_sum,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count,
  output state_e             dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a source holds valid and its payload stable until that edge, and ready never waits on a later cycle.
  state_e             r_state;
  logic [FP_W-1:0]    r_a, r_b, r_sum;
  logic [ID_W-1:0]    r_id, r_last_grant;
  logic [COUNT_W-1:0] r_op_count;
  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [FP_W-1:0]    w_sum;

  // On a tie the requester that did not win last time goes first.
  assign w_grant[0] = req_valid[0] & (~req_valid[1] | (r_last_grant == 1'b1));
  assign w_grant[1] = req_valid[1] & (~req_valid[0] | (r_last_grant == 1'b0));
  assign w_grant_id = w_grant[1] ? 1'b1 : 1'b0;

  assign req_ready = ((r_state == ST_IDLE) && !rst) ? w_grant : '0;
  assign rsp_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;
  assign op_count  = r_op_count;
  assign dbg_state = r_state;

  fp_adder u_fp_adder (
    .A   (r_a),
    .B   (r_b),
    .Sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(1);
      r_op_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_a          <= w_grant[1] ? req1_a : req0_a;
            r_b          <= w_grant[1] ? req1_b : req0_b;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_sum   <= w_sum;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
            if (r_op_count != '1) r_op_count <= r_op_count + COUNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: directed scenarios plus randomized traffic checked
// against a real-arithmetic float model and a round-robin arbitration model.
module tb_fp_add_sched;
  import fp_add_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, busy;
  logic [31:0] rsp_sum;
  logic        rsp_ready = 1'b0;
  logic [15:0] op_count;
  state_e      dbg_state;

  logic [1:0]  s_req_valid = 2'b00;
  logic [31:0] s_req0_a = '0, s_req0_b = '0;
  logic [1:0]  s_req_ready;
  logic        s_rsp_valid, s_rsp_id, s_busy;
  logic [31:0] s_rsp_sum;
  logic        s_rsp_ready = 1'b0;
  logic [1:0]  s_op_count;
  state_e      s_dbg_state;

  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;
  logic        last_model = 1'b1;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  fp_add_sched #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_ready(rsp_ready), .busy(busy),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  fp_add_sched #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(s_req_valid),
    .req0_a(s_req0_a), .req0_b(s_req0_b), .req1_a(32'h0), .req1_b(32'h0),
    .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id),
    .rsp_sum(s_rsp_sum), .rsp_ready(s_rsp_ready), .busy(s_busy),
    .op_count(s_op_count), .dbg_state(s_dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic real fp_to_real(input logic [31:0] x);
    real m;
    int  e;
    int  fi;
    if (x[30:23] == 8'd0) return 0.0;
    fi = int'(x[22:0]);
    m  = 1.0 + fi / 8388608.0;
    e  = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    real         m, f, rem;
    int          e, q;
    logic        s;
    logic [31:0] qb, eb;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f   = m * 8388608.0;
    q   = $rtoi(f);
    rem = f - q;
    if (rem > 0.5 || (rem == 0.5 && (q % 2) == 1)) q++;
    if (q == 16777216) begin q = 8388608; e++; end
    qb = q;
    eb = e;
    return {s, eb[7:0], qb[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp(fp_to_real(a) + fp_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    e = 8'($urandom_range(100, 150));
    f = 23'($urandom);
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    last_model = 1'b1;
  endtask

  // Waits (bounded) for a grant; after the accepting edge drops the granted valid bit.
  task automatic wait_grant(output logic [1:0] gnt);
    gnt = 2'b00;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready != 2'b00) begin
        gnt = req_ready;
        break;
      end
      tick();
    end
    if (gnt != 2'b00) begin
      tick();
      req_valid = req_valid & ~gnt;
    end
  endtask

  // Waits (bounded) for a response, stalls `delay` cycles, then completes the handshake.
  task automatic collect(input int delay, output logic [31:0] sum, output logic id,
                         output logic got);
    got = 1'b0;
    sum = '0;
    id  = 1'b0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) break;
      tick();
    end
    if (rsp_valid) begin
      sum = rsp_sum;
      id  = rsp_id;
      repeat (delay) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      got = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #12;
    checks += 6;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
    if (rsp_sum !== 32'h0) begin failures++; $display("FAIL reset_rsp_sum got=%h want=0", rsp_sum); end
    if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] g;
    logic [31:0] s;
    logic id, got;
    req0_a = 32'h4040_0000; req0_b = 32'h4000_0000; req_valid = 2'b01;
    wait_grant(g);
    last_model = 1'b0;
    checks += 3;
    if (g !== 2'b01) begin failures++; $display("FAIL single0_grant got=%b want=01", g); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single0_valid_n1 got=%b want=0", rsp_valid); end
    if (busy !== 1'b1) begin failures++; $display("FAIL single0_busy got=%b want=1", busy); end
    tick();
    checks += 3;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single0_valid_n2 got=%b want=1", rsp_valid); end
    if (rsp_sum !== 32'h40A0_0000) begin failures++; $display("FAIL single0_sum got=%h want=40a00000", rsp_sum); end
    if (rsp_id !== 1'b0) begin failures++; $display("FAIL single0_id got=%b want=0", rsp_id); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_cnt++;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL single0_idle got=%b want=0", busy); end
    if (op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL single0_count got=%0d want=%0d", op_count, exp_cnt); end

    // Consumer already ready on the first DONE cycle.
    req1_a = 32'hC040_0000; req1_b = 32'h4000_0000; req_valid = 2'b10;
    wait_grant(g);
    last_model = 1'b1;
    rsp_ready = 1'b1;
    checks += 1;
    if (g !== 2'b10) begin failures++; $display("FAIL single1_grant got=%b want=10", g); end
    tick();
    checks += 3;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single1_valid got=%b want=1", rsp_valid); end
    if (rsp_sum !== 32'hBF80_0000) begin failures++; $display("FAIL single1_sum got=%h want=bf800000", rsp_sum); end
    if (rsp_id !== 1'b1) begin failures++; $display("FAIL single1_id got=%b want=1", rsp_id); end
    tick();
    rsp_ready = 1'b0;
    exp_cnt++;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL single1_first_done_hs got=%b want=0", busy); end
    if (op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL single1_count got=%0d want=%0d", op_count, exp_cnt); end

    req0_a = 32'h3F80_0000; req0_b = 32'hBF80_0000; req_valid = 2'b01;
    wait_grant(g);
    last_model = 1'b0;
    collect(1, s, id, got);
    exp_cnt++;
    checks += 3;
    if (got !== 1'b1) begin failures++; $display("FAIL cancel_timeout got=%b want=1", got); end
    if (s !== 32'h0) begin failures++; $display("FAIL cancel_sum got=%h want=00000000", s); end
    if (id !== 1'b0) begin failures++; $display("FAIL cancel_id got=%b want=0", id); end
  endtask

  task automatic test_tie();
    logic [1:0] g;
    logic [31:0] s;
    logic id, got;
    pulse_reset();
    req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    req1_a = 32'h4040_0000; req1_b = 32'h4000_0000;
    req_valid = 2'b11;
    wait_grant(g);
    checks += 2;
    if (g !== 2'b01) begin failures++; $display("FAIL tie_first_grant got=%b want=01", g); end
    if (req_ready !== 2'b00) begin failures++; $display("FAIL tie_ignore_exec got=%b want=00", req_ready); end
    collect(1, s, id, got);
    exp_cnt++;
    checks += 2;
    if (got !== 1'b1 || s !== 32'h4000_0000) begin failures++; $display("FAIL tie_first_sum got=%h want=40000000", s); end
    if (id !== 1'b0) begin failures++; $display("FAIL tie_first_id got=%b want=0", id); end
    wait_grant(g);
    checks += 1;
    if (g !== 2'b10) begin failures++; $display("FAIL tie_second_grant got=%b want=10", g); end
    collect(0, s, id, got);
    exp_cnt++;
    last_model = 1'b1;
    checks += 3;
    if (got !== 1'b1 || s !== 32'h40A0_0000) begin failures++; $display("FAIL tie_second_sum got=%h want=40a00000", s); end
    if (id !== 1'b1) begin failures++; $display("FAIL tie_second_id got=%b want=1", id); end
    if (op_count !== 16'd2) begin failures++; $display("FAIL tie_count got=%0d want=2", op_count); end
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    logic [31:0] a, b, e;
    a = rand_fp(); b = rand_fp(); e = ref_add(a, b);
    req0_a = a; req0_b = b; req_valid = 2'b01;
    wait_grant(g);
    last_model = 1'b0;
    tick();
    req1_a = rand_fp(); req1_b = rand_fp(); req_valid = 2'b11;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks += 5;
      if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b want=1", k, rsp_valid); end
      if (rsp_sum !== e) begin failures++; $display("FAIL bp_sum cyc=%0d got=%h want=%h", k, rsp_sum, e); end
      if (rsp_id !== 1'b0) begin failures++; $display("FAIL bp_id cyc=%0d got=%b want=0", k, rsp_id); end
      if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_req_ready cyc=%0d got=%b want=00", k, req_ready); end
      if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy cyc=%0d got=%b want=1", k, busy); end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_cnt++;
    checks += 2;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_complete got=%b want=0", rsp_valid); end
    if (op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL bp_count got=%0d want=%0d", op_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    logic [31:0] s, a0, b0, a1, b1;
    logic id, got, seen;
    req1_a = rand_fp(); req1_b = rand_fp(); req_valid = 2'b10;
    wait_grant(g);
    #2;
    rst = 1'b1;
    #2;
    checks += 4;
    if (g !== 2'b10) begin failures++; $display("FAIL rmid_grant got=%b want=10", g); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b want=0", rsp_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (op_count !== 16'd0) begin failures++; $display("FAIL rmid_count got=%0d want=0", op_count); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    last_model = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks += 1;
    if (seen !== 1'b0) begin failures++; $display("FAIL rmid_no_response got=%b want=0", seen); end
    a0 = rand_fp(); b0 = rand_fp(); a1 = rand_fp(); b1 = rand_fp();
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1; req_valid = 2'b11;
    wait_grant(g);
    checks += 1;
    if (g !== 2'b01) begin failures++; $display("FAIL rmid_tie_grant got=%b want=01", g); end
    collect(0, s, id, got);
    exp_cnt++;
    checks += 1;
    if (got !== 1'b1 || {id, s} !== {1'b0, ref_add(a0, b0)}) begin
      failures++; $display("FAIL rmid_tie_rsp got=%b/%h want=0/%h", id, s, ref_add(a0, b0));
    end
    wait_grant(g);
    collect(2, s, id, got);
    exp_cnt++;
    last_model = 1'b1;
    checks += 2;
    if (got !== 1'b1 || {id, s} !== {1'b1, ref_add(a1, b1)}) begin
      failures++; $display("FAIL rmid_second_rsp got=%b/%h want=1/%h", id, s, ref_add(a1, b1));
    end
    if (op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rmid_count_after got=%0d want=%0d", op_count, exp_cnt); end
  endtask

  task automatic test_random();
    logic        pend_v[2];
    logic [31:0] pend_a[2], pend_b[2];
    logic [1:0]  g, exp_g;
    logic        exp_id, id, got;
    logic [31:0] s;
    logic [32:0] e;
    int          r;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend_v[k] && $urandom_range(0, 1) == 1) begin
          pend_v[k] = 1'b1; pend_a[k] = rand_fp();
          pend_b[k] = ($urandom_range(0, 7) == 0) ? {~pend_a[k][31], pend_a[k][30:0]} : rand_fp();
        end
      end
      if (!pend_v[0] && !pend_v[1]) begin
        r = $urandom_range(0, 1);
        pend_v[r] = 1'b1; pend_a[r] = rand_fp(); pend_b[r] = rand_fp();
      end
      exp_id = (pend_v[0] && pend_v[1]) ? ~last_model : pend_v[1];
      exp_g  = exp_id ? 2'b10 : 2'b01;
      exp_q.push_back({exp_id, ref_add(pend_a[exp_id], pend_b[exp_id])});
      req0_a = pend_a[0]; req0_b = pend_b[0];
      req1_a = pend_a[1]; req1_b = pend_b[1];
      req_valid = {pend_v[1], pend_v[0]};
      wait_grant(g);
      pend_v[exp_id] = 1'b0;
      last_model = exp_id;
      checks += 1;
      if (g !== exp_g) begin failures++; $display("FAIL rand_grant it=%0d got=%b want=%b", it, g, exp_g); end
      collect($urandom_range(0, 3), s, id, got);
      exp_cnt++;
      e = exp_q.pop_front();
      checks += 2;
      if (got !== 1'b1 || {id, s} !== e) begin
        failures++; $display("FAIL rand_rsp it=%0d got=%b/%h want=%b/%h", it, id, s, e[32], e[31:0]);
      end
      if (op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rand_count it=%0d got=%0d want=%0d", it, op_count, exp_cnt); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_saturation();
    int n;
    int want;
    n = 0;
    s_req0_a = 32'h3F80_0000; s_req0_b = 32'h3F80_0000;
    s_rsp_ready = 1'b1;
    s_req_valid = 2'b01;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (s_rsp_valid) begin
        n++;
        if (n == 5) s_req_valid = 2'b00;
        tick();
        want = (n > 3) ? 3 : n;
        checks += 1;
        if (s_op_count !== 2'(want)) begin failures++; $display("FAIL sat_count op=%0d got=%0d want=%0d", n, s_op_count, want); end
      end else begin
        tick();
      end
    end
    s_req_valid = 2'b00;
    s_rsp_ready = 1'b0;
    checks += 2;
    if (n != 5) begin failures++; $display("FAIL sat_timeout got=%0d ops want=5", n); end
    if (s_op_count !== 2'd3) begin failures++; $display("FAIL sat_final got=%0d want=3", s_op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
